// File: rtl/input_cond_pkg.sv
// Shared constants and key FSM state type for the input conditioner.
// Default timing assumes a 50 MHz system clock.
package input_cond_pkg;

    localparam int CLK_HZ = 50000000;

    // 10 ms of stable level before an input is accepted
    localparam int DEFAULT_DEBOUNCE_CYCLES = CLK_HZ / 100;

    // 500 ms hold before the first repeat, then one every 100 ms
    localparam int DEFAULT_REPEAT_DELAY_CYCLES = CLK_HZ / 2;
    localparam int DEFAULT_REPEAT_RATE_CYCLES = CLK_HZ / 10;

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        REPEAT
    } key_state_t;

endpackage

// File: rtl/input_conditioner_debounce_bit.sv
// One conditioned channel: 2-flop synchronizer followed by a
// counter debouncer. flip is high in the cycle before level updates.
module debounce_bit
    import input_cond_pkg::*;
#(
    parameter logic RESET_VAL       = 1'b0,
    parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic flip
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          at_limit;

    assign at_limit = (cnt == CW'(DEBOUNCE_CYCLES - 1));
    assign flip     = (sync2 != level) && at_limit;

    // Synchronize, then accept a new level only after it holds long enough
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= RESET_VAL;
            sync2 <= RESET_VAL;
            level <= RESET_VAL;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (at_limit) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// Debounces board switches and the push-key for the SoC PIO inputs and
// generates press/change pulses. Build option: INPUT_CONDITIONER_AUTO_REPEAT_EN.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int SW_WIDTH            = 8,
    parameter int DEBOUNCE_CYCLES     = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY_CYCLES = DEFAULT_REPEAT_DELAY_CYCLES,
    parameter int REPEAT_RATE_CYCLES  = DEFAULT_REPEAT_RATE_CYCLES
) (
    input  logic                clk_clk,
    input  logic                reset_reset,
    input  logic [SW_WIDTH-1:0] sw_raw,
    input  logic                key_raw,
    output logic [SW_WIDTH-1:0] sw_wire_export,
    output logic                key_wire_export,
    output logic                key_press,
    output logic                sw_changed,
    output logic [SW_WIDTH-1:0] sw_changed_mask
);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 2");
    end

    if (REPEAT_DELAY_CYCLES < 1 || REPEAT_RATE_CYCLES < 1) begin : g_bad_repeat
        $error("REPEAT_*_CYCLES must be at least 1");
    end

    logic [SW_WIDTH-1:0] sw_flip;
    logic                key_flip;
    logic                key_fall;
    logic                key_rise;
    logic                press_next;
    key_state_t          state;
    key_state_t          state_next;

    for (genvar i = 0; i < SW_WIDTH; i++) begin : g_sw
        debounce_bit #(
            .RESET_VAL       (1'b0),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_sw (
            .clk   (clk_clk),
            .reset (reset_reset),
            .raw   (sw_raw[i]),
            .level (sw_wire_export[i]),
            .flip  (sw_flip[i])
        );
    end

    debounce_bit #(
        .RESET_VAL       (1'b1),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key (
        .clk   (clk_clk),
        .reset (reset_reset),
        .raw   (key_raw),
        .level (key_wire_export),
        .flip  (key_flip)
    );

    // The key is active-low: a flip from 1 is a press, from 0 a release
    assign key_fall = key_flip & key_wire_export;
    assign key_rise = key_flip & ~key_wire_export;

`ifdef INPUT_CONDITIONER_AUTO_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                             REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
    localparam int RW = $clog2(RPT_MAX + 1);

    logic [RW-1:0] rpt_cnt;
    logic [RW-1:0] rpt_next;

    // Repeat timer; cleared on every state transition
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            rpt_cnt <= '0;
        end else begin
            rpt_cnt <= rpt_next;
        end
    end
`endif

    // Key FSM next state; pulses coincide with the stable-level edge
    always_comb begin
        state_next = state;
        press_next = 1'b0;
`ifdef INPUT_CONDITIONER_AUTO_REPEAT_EN
        rpt_next   = rpt_cnt;
`endif
        case (state)
            IDLE: begin
                if (key_fall) begin
                    state_next = HELD;
                    press_next = 1'b1;
`ifdef INPUT_CONDITIONER_AUTO_REPEAT_EN
                    rpt_next   = '0;
`endif
                end
            end
            HELD: begin
                if (key_rise) begin
                    state_next = IDLE;
`ifdef INPUT_CONDITIONER_AUTO_REPEAT_EN
                    rpt_next   = '0;
                end else if (rpt_cnt == RW'(REPEAT_DELAY_CYCLES - 1)) begin
                    state_next = REPEAT;
                    press_next = 1'b1;
                    rpt_next   = '0;
                end else begin
                    rpt_next   = rpt_cnt + 1'b1;
`endif
                end
            end
`ifdef INPUT_CONDITIONER_AUTO_REPEAT_EN
            REPEAT: begin
                if (key_rise) begin
                    state_next = IDLE;
                    rpt_next   = '0;
                end else if (rpt_cnt == RW'(REPEAT_RATE_CYCLES - 1)) begin
                    press_next = 1'b1;
                    rpt_next   = '0;
                end else begin
                    rpt_next   = rpt_cnt + 1'b1;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // Register FSM state and event pulses on the edge the levels update
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state           <= IDLE;
            key_press       <= 1'b0;
            sw_changed      <= 1'b0;
            sw_changed_mask <= '0;
        end else begin
            state           <= state_next;
            key_press       <= press_next;
            sw_changed      <= |sw_flip;
            sw_changed_mask <= sw_flip;
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench: each stimulus queues the output event it should cause;
// a negedge monitor pops and compares every observed event.
module tb_input_conditioner;

    localparam int SW = 8;
    localparam int LAT = 6;
`ifdef INPUT_CONDITIONER_AUTO_REPEAT_EN
    localparam int HOLD = 30;
`else
    localparam int HOLD = 20;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [SW-1:0] sw_raw = '0;
    logic          key_raw = 1'b1;
    logic [SW-1:0] sw_wire_export;
    logic          key_wire_export;
    logic          key_press;
    logic          sw_changed;
    logic [SW-1:0] sw_changed_mask;

    input_conditioner #(
        .SW_WIDTH            (SW),
        .DEBOUNCE_CYCLES     (4),
        .REPEAT_DELAY_CYCLES (10),
        .REPEAT_RATE_CYCLES  (3)
    ) dut (
        .clk_clk         (clk),
        .reset_reset     (reset),
        .sw_raw          (sw_raw),
        .key_raw         (key_raw),
        .sw_wire_export  (sw_wire_export),
        .key_wire_export (key_wire_export),
        .key_press       (key_press),
        .sw_changed      (sw_changed),
        .sw_changed_mask (sw_changed_mask)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic [SW-1:0] sw;
        logic          key;
        logic          press;
        logic          chg;
        logic [SW-1:0] mask;
    } obs_t;

    obs_t          exp_q[$];
    obs_t          cur;
    int            n_cmp = 0;
    int            n_bad = 0;
    logic          mon_en = 1'b0;
    logic [SW-1:0] prev_sw = '0;
    logic          prev_key = 1'b1;
    logic [SW-1:0] exp_sw = '0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic expect_obs(input int c, input logic [SW-1:0] sw,
                              input logic key, input logic press,
                              input logic chg, input logic [SW-1:0] mask);
        obs_t o;
        o.cyc   = c;
        o.sw    = sw;
        o.key   = key;
        o.press = press;
        o.chg   = chg;
        o.mask  = mask;
        exp_q.push_back(o);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_sw(input logic [SW-1:0] v);
        sw_raw = v;
        expect_obs(cyc + LAT, v, 1'b1, 1'b0, 1'b1, v ^ exp_sw);
        exp_sw = v;
        idle(12);
    endtask

    task automatic key_hold(input int hold);
        int p;
        key_raw = 1'b0;
        p = cyc + LAT;
        expect_obs(p, exp_sw, 1'b0, 1'b1, 1'b0, '0);
`ifdef INPUT_CONDITIONER_AUTO_REPEAT_EN
        for (int t = p + 10; t < p + hold; t += 3)
            expect_obs(t, exp_sw, 1'b0, 1'b1, 1'b0, '0);
`endif
        idle(hold);
        key_raw = 1'b1;
        expect_obs(cyc + LAT, exp_sw, 1'b1, 1'b0, 1'b0, '0);
        idle(12);
    endtask

    // Any pulse, stray mask or level change is an event to be accounted for
    always @(negedge clk) begin
        if (mon_en) begin
            if (key_press || sw_changed || sw_changed_mask != '0 ||
                sw_wire_export != prev_sw || key_wire_export != prev_key) begin
                if (exp_q.size() == 0) begin
                    check("spurious_event", 32'(exp_q.size()), 32'd1);
                end else begin
                    cur = exp_q.pop_front();
                    check("event_cycle", 32'(cyc), 32'(cur.cyc));
                    check("sw_level", 32'(sw_wire_export), 32'(cur.sw));
                    check("key_level", 32'(key_wire_export), 32'(cur.key));
                    check("key_press", 32'(key_press), 32'(cur.press));
                    check("sw_changed", 32'(sw_changed), 32'(cur.chg));
                    check("sw_mask", 32'(sw_changed_mask), 32'(cur.mask));
                end
            end
            prev_sw  = sw_wire_export;
            prev_key = key_wire_export;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset   = 1'b1;
        sw_raw  = 8'hFF;
        key_raw = 1'b0;
        idle(4);
        check("rst_sw", 32'(sw_wire_export), 32'h00);
        check("rst_key", 32'(key_wire_export), 32'h1);
        check("rst_press", 32'(key_press), 32'h0);
        check("rst_chg", 32'(sw_changed), 32'h0);
        check("rst_mask", 32'(sw_changed_mask), 32'h00);

        reset   = 1'b0;
        key_raw = 1'b1;
        mon_en  = 1'b1;
        expect_obs(cyc + LAT, 8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF);
        exp_sw = 8'hFF;
        idle(12);

        drive_sw(8'h00);
        drive_sw(8'h08);

        key_raw = 1'b0;
        idle(3);
        key_raw = 1'b1;
        idle(12);

        key_hold(HOLD);

        drive_sw(8'h00);
        drive_sw(8'h81);

        sw_raw = 8'h7E;
        idle(3);
        reset = 1'b1;
        expect_obs(cyc + 1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        exp_sw = 8'h00;
        idle(1);
        reset  = 1'b0;
        sw_raw = 8'h00;
        idle(12);

        drive_sw(8'h7E);

        check("events_pending", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Conditions the raw board switches and push-key before they reach the SoC PIO inputs `sw_wire_export[7:0]` and `key_wire_export`. It sits directly upstream of the SoC.
- Per bit: 2-flop synchronizer, then a counter-based debouncer, so the SoC only ever sees clean, stable levels.
- Also produces single-cycle event pulses (key press, switch change) for fabric logic, e.g. the tank fire control.

Parameters:
- SW_WIDTH, 8, number of switch channels.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed before an output updates (10 ms at 50 MHz); legal range ≥ 2.
- REPEAT_DELAY_CYCLES, 25000000, hold time before the first auto-repeat pulse (AUTO_REPEAT_EN only).
- REPEAT_RATE_CYCLES, 5000000, interval between auto-repeat pulses (AUTO_REPEAT_EN only).

Ports:
- clk_clk  in  1  system clock (50 MHz), same net that drives the SoC.
- reset_reset  in  1  synchronous, active-high reset.
- sw_raw  in  SW_WIDTH  raw asynchronous switch levels.
- key_raw  in  1  raw asynchronous push-key, active-low (0 = pressed).
- sw_wire_export  out  SW_WIDTH  debounced switch levels; feeds the SoC PIO.
- key_wire_export  out  1  debounced key level, active-low; feeds the SoC PIO.
- key_press  out  1  one-cycle pulse per accepted press.
- sw_changed  out  1  one-cycle pulse when any debounced switch bit updates.
- sw_changed_mask  out  SW_WIDTH  bits that updated; valid only while sw_changed = 1, otherwise 0.

Behaviour:
- Clocking and reset
  - One clock, clk_clk; reset is synchronous and active-high (reset_reset).
  - Everything is sampled on the rising edge of clk_clk.
  - Reset values:
    - switch sync flops, switch counters and sw_wire_export = 0;
    - key sync flops and key_wire_export = 1 (released);
    - key_press, sw_changed, sw_changed_mask = 0;
    - key FSM = IDLE.
  - Reset mid-debounce discards the partial count. Outputs return to reset values on the next edge.
- Per channel (identical for each switch bit and for the key)
  - sync1 <= raw; sync2 <= sync1.
  - If sync2 == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= sync2, cnt <= 0.
  - Else: cnt <= cnt+1.
  - Counter width is $clog2(DEBOUNCE_CYCLES); it never wraps.
- Latency and glitch rejection
  - A raw change held steady is first sampled at edge E. The output updates at edge E+DEBOUNCE_CYCLES+1.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles (after sync) resets the count and never reaches the output.
- Event pulses
  - sw_changed and sw_changed_mask are registered on the same edge that the stable bits update.
  - Multiple bits updating on the same edge produce one pulse with multiple mask bits set.
- Key FSM (one-hot or binary)
  - IDLE: on the stable key 1->0 edge, assert key_press for that cycle and go to HELD.
  - HELD: on stable key back to 1, go to IDLE. With AUTO_REPEAT_EN, the repeat timer also runs in this state (see Optional Feature).
  - REPEAT: exists only with AUTO_REPEAT_EN. On stable key back to 1, go to IDLE.
  - key_press is asserted in the same cycle that key_wire_export first reads 0.
  - Release generates no pulse.

Optional Feature:
- Macro: INPUT_CONDITIONER_AUTO_REPEAT_EN.
- Defined:
  - HELD counts REPEAT_DELAY_CYCLES. When the count expires, pulse key_press and enter REPEAT.
  - REPEAT pulses key_press every REPEAT_RATE_CYCLES while the key is held.
  - Release resets the timer and returns to IDLE; any press that follows is handled as a fresh first press.
- Undefined:
  - Repeat timer and REPEAT state are absent; REPEAT_* parameters are ignored.
  - Exactly one key_press per press.

Decomposition:
- Package input_cond_pkg holds:
  - the default constants (CLK_HZ = 50000000, DEBOUNCE_CYCLES, REPEAT_* defaults);
  - the key FSM state typedef key_state_t {IDLE, HELD, REPEAT}.
- Sub-module debounce_bit:
  - contains the sync, counter and stable register for one channel;
  - parameters RESET_VAL and DEBOUNCE_CYCLES;
  - instantiated SW_WIDTH+1 times, once per switch bit plus once for the key.
- The top level adds the pulse logic and the key FSM.

Test Plan (bench uses DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=10, REPEAT_RATE_CYCLES=3):
- Reset with sw_raw=8'hFF, key_raw=0 -> sw_wire_export=8'h00, key_wire_export=1, no pulses; after release, sw_wire_export=8'hFF at sample edge+5.
- sw_raw[3] 0->1 held -> sw_wire_export[3]=1 exactly 5 edges after first sample; sw_changed=1 and sw_changed_mask=8'h08 for one cycle.
- key_raw low for 3 cycles then high (glitch) -> key_wire_export stays 1, key_press never asserts.
- key_raw low held 20 cycles -> key_wire_export=0 at E+5 with one key_press pulse; without the macro, no further pulses.
- With INPUT_CONDITIONER_AUTO_REPEAT_EN, key held 30 cycles -> pulses at press, +10, +13, +16...; release returns to IDLE with no pulse.
- sw_raw 8'h00->8'h81 on the same edge -> single sw_changed pulse with mask 8'h81; assert reset_reset mid-count -> no update, counters cleared.
